// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer:
// opcodes, FSM state encoding and instruction word fields.
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_DIV   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int IR_OP_HI = 15;
    localparam int IR_OP_LO = 12;
    localparam int IR_AD_HI = 7;
    localparam int IR_AD_LO = 0;
    localparam int IR_AD_W  = IR_AD_HI - IR_AD_LO + 1;

    typedef enum logic [3:0] {
        S_F1,
        S_F2,
        S_DEC,
        S_RD,
        S_ALU,
        S_ST,
        S_DCHK,
        S_DW1,
        S_DW2,
        S_HALT
    } state_t;

endpackage

// File: rtl/acc_cpu_regs.sv
// Architectural register file of the accumulator CPU:
// PC, IR, ACC, MDR, MAR and Z, each with its own load enable.
module acc_cpu_regs #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter int                AD_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pc_en_i,
    input  logic [ADDR_W-1:0] pc_d_i,
    input  logic              ir_en_i,
    input  logic [3:0]        ir_op_d_i,
    input  logic [AD_W-1:0]   ir_ad_d_i,
    input  logic              acc_en_i,
    input  logic [DATA_W-1:0] acc_d_i,
    input  logic              mdr_en_i,
    input  logic [DATA_W-1:0] mdr_d_i,
    input  logic              mar_en_i,
    input  logic [ADDR_W-1:0] mar_d_i,
    input  logic              z_en_i,
    input  logic              z_d_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [3:0]        ir_op_o,
    output logic [AD_W-1:0]   ir_ad_o,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] mdr_o,
    output logic [ADDR_W-1:0] mar_o,
    output logic              z_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        ir_op_q;
    logic [AD_W-1:0]   ir_ad_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mdr_q;
    logic [ADDR_W-1:0] mar_q;
    logic              z_q;

    // IR[11:8] has no meaning in the ISA, so only the decoded fields are held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= RESET_PC;
            ir_op_q <= '0;
            ir_ad_q <= '0;
            acc_q   <= '0;
            mdr_q   <= '0;
            mar_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            if (pc_en_i) pc_q <= pc_d_i;
            if (ir_en_i) begin
                ir_op_q <= ir_op_d_i;
                ir_ad_q <= ir_ad_d_i;
            end
            if (acc_en_i) acc_q <= acc_d_i;
            if (mdr_en_i) mdr_q <= mdr_d_i;
            if (mar_en_i) mar_q <= mar_d_i;
            if (z_en_i)   z_q   <= z_d_i;
        end
    end

    assign pc_o    = pc_q;
    assign ir_op_o = ir_op_q;
    assign ir_ad_o = ir_ad_q;
    assign acc_o   = acc_q;
    assign mdr_o   = mdr_q;
    assign mar_o   = mar_q;
    assign z_o     = z_q;

endmodule

// File: rtl/acc_cpu_ctrl.sv
// Multicycle fetch/decode/execute sequencer of the accumulator CPU.
// Drives the RAM port and the iterative divider handshake.
module acc_cpu_ctrl
    import acc_cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    output logic              div_load,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_q,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              zflag,
    output logic              halted,
    output logic              div_err
);

    state_t state_q;
    logic   mem_we_q;
    logic   div_load_q;
    logic   halted_q;
    logic   div_err_q;

    logic [ADDR_W-1:0]  pc_q;
    logic [3:0]         ir_op_q;
    logic [IR_AD_W-1:0] ir_ad_q;
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  mdr_q;
    logic [ADDR_W-1:0]  mar_q;
    logic               z_q;

    logic               pc_en;
    logic [ADDR_W-1:0]  pc_d;
    logic               ir_en;
    logic               acc_en;
    logic [DATA_W-1:0]  acc_d;
    logic               mdr_en;
    logic [DATA_W-1:0]  mdr_d;
    logic               mar_en;
    logic [ADDR_W-1:0]  mar_d;
    logic               z_d;
    logic [ADDR_W-1:0]  opnd;

    assign opnd = ADDR_W'(ir_ad_q);

    acc_cpu_regs #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .AD_W     (IR_AD_W),
        .RESET_PC (RESET_PC)
    ) u_regs (
        .clk_i     (clk),
        .rst_ni    (rst),
        .pc_en_i   (pc_en),
        .pc_d_i    (pc_d),
        .ir_en_i   (ir_en),
        .ir_op_d_i (mem_rdata[IR_OP_HI:IR_OP_LO]),
        .ir_ad_d_i (mem_rdata[IR_AD_HI:IR_AD_LO]),
        .acc_en_i  (acc_en),
        .acc_d_i   (acc_d),
        .mdr_en_i  (mdr_en),
        .mdr_d_i   (mdr_d),
        .mar_en_i  (mar_en),
        .mar_d_i   (mar_d),
        .z_en_i    (acc_en),
        .z_d_i     (z_d),
        .pc_o      (pc_q),
        .ir_op_o   (ir_op_q),
        .ir_ad_o   (ir_ad_q),
        .acc_o     (acc_q),
        .mdr_o     (mdr_q),
        .mar_o     (mar_q),
        .z_o       (z_q)
    );

    always_comb begin
        pc_en  = 1'b0;
        pc_d   = pc_q + ADDR_W'(1);
        ir_en  = 1'b0;
        acc_en = 1'b0;
        acc_d  = acc_q;
        mdr_en = 1'b0;
        mdr_d  = mem_rdata;
        mar_en = 1'b0;
        mar_d  = pc_q;
        case (state_q)
            S_F1: mar_en = 1'b1;
            S_F2: begin
                ir_en = 1'b1;
                pc_en = 1'b1;
            end
            S_DEC: begin
                mar_en = 1'b1;
                mar_d  = opnd;
                pc_d   = opnd;
                pc_en  = (ir_op_q == OP_JMP) ||
                         ((ir_op_q == OP_JZ) && z_q);
            end
            S_RD: mdr_en = 1'b1;
            S_ALU: begin
                acc_en = 1'b1;
                case (ir_op_q)
                    OP_ADD:  acc_d = acc_q + mdr_q;
                    OP_SUB:  acc_d = acc_q - mdr_q;
                    default: acc_d = mdr_q;
                endcase
            end
            S_ST: begin
                mdr_en = 1'b1;
                mdr_d  = acc_q;
            end
            S_DCHK: begin
                acc_en = (mdr_q == '0);
                acc_d  = '1;
            end
            S_DW2: begin
                acc_en = div_done;
                acc_d  = div_q;
            end
            default: ;
        endcase
    end

    assign z_d = (acc_d == '0);

    // Strobes are registered on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_F1;
            mem_we_q   <= 1'b0;
            div_load_q <= 1'b0;
            halted_q   <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            div_load_q <= 1'b0;
            case (state_q)
                S_F1: state_q <= S_F2;
                S_F2: state_q <= S_DEC;
                S_DEC: begin
                    case (ir_op_q)
                        OP_STORE: begin
                            state_q  <= S_ST;
                            mem_we_q <= 1'b1;
                        end
                        OP_LOAD, OP_ADD, OP_SUB, OP_DIV:
                            state_q <= S_RD;
                        OP_HALT: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default: state_q <= S_F1;
                    endcase
                end
                S_RD: begin
                    if (ir_op_q == OP_DIV) begin
                        state_q    <= S_DCHK;
                        div_load_q <= (mem_rdata != '0);
                    end else begin
                        state_q <= S_ALU;
                    end
                end
                S_ALU: state_q <= S_F1;
                S_ST:  state_q <= S_F1;
                S_DCHK: begin
                    if (mdr_q == '0) begin
                        state_q   <= S_F1;
                        div_err_q <= 1'b1;
                    end else begin
                        state_q <= S_DW1;
                    end
                end
                // div_done is still high from the previous divide here.
                S_DW1: state_q <= S_DW2;
                S_DW2: if (div_done) state_q <= S_F1;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_F1;
            endcase
        end
    end

    assign mem_addr  = mar_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = acc_q;
    assign div_a     = acc_q;
    assign div_b     = mdr_q;
    assign div_load  = div_load_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign zflag     = z_q;
    assign halted    = halted_q;
    assign div_err   = div_err_q;

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Bench for acc_cpu_ctrl: directed programs plus random programs,
// checked per instruction against an ISA-level reference model.
module tb_acc_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic        div_load;
    logic        d_done = 1'b1;
    logic [15:0] d_q = 16'h0;
    logic [7:0]  pc;
    logic [15:0] acc;
    logic        zflag;
    logic        halted;
    logic        div_err;

    always #5 clk = ~clk;

    acc_cpu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_load  (div_load),
        .div_done  (d_done),
        .div_q     (d_q),
        .pc        (pc),
        .acc       (acc),
        .zflag     (zflag),
        .halted    (halted),
        .div_err   (div_err)
    );

    logic [15:0] ram [256];
    assign mem_rdata = ram[mem_addr];

    // Divider model: done drops one cycle after the load, rises div_lat later.
    logic        arm = 1'b0;
    int          cnt = 0;
    int          div_lat = 2;
    logic [15:0] la = 16'h0;
    logic [15:0] lb = 16'h1;
    int          unstable = 0;

    always @(posedge clk) begin
        if ((arm || cnt != 0) && (div_a !== la || div_b !== lb))
            unstable <= unstable + 1;
        if (div_load === 1'b1) begin
            arm <= 1'b1;
            la  <= div_a;
            lb  <= div_b;
        end else if (arm) begin
            arm    <= 1'b0;
            d_done <= 1'b0;
            cnt    <= div_lat;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                d_done <= 1'b1;
                d_q    <= la / lb;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int ld_cnt = 0;
    int exp_we = 0;
    int exp_ld = 0;

    logic [7:0]  m_pc;
    logic [15:0] m_acc;
    logic [15:0] m_mdr;
    logic        m_z;
    logic        m_err;
    logic        m_halt;
    logic [15:0] mmem [256];
    logic [3:0]  rop;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            if (mem_we === 1'b1) begin
                ram[mem_addr] = mem_wdata;
                we_cnt++;
            end
            if (div_load === 1'b1) ld_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic mreset();
        m_pc   = 8'h00;
        m_acc  = 16'h0;
        m_mdr  = 16'h0;
        m_z    = 1'b0;
        m_err  = 1'b0;
        m_halt = 1'b0;
        for (int i = 0; i < 256; i++) mmem[i] = ram[i];
        exp_we = we_cnt;
        exp_ld = ld_cnt;
    endtask

    task automatic hw_reset();
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mreset();
    endtask

    // One instruction of the ISA, with its architectural cycle cost.
    task automatic step();
        logic [15:0] ins;
        logic [3:0]  op;
        logic [7:0]  a;
        logic        st;
        int          n;
        st = 1'b0;
        a  = 8'h0;
        n  = 3;
        if (!m_halt) begin
            ins  = mmem[m_pc];
            op   = ins[15:12];
            a    = ins[7:0];
            m_pc = m_pc + 8'd1;
            case (op)
                4'h1: begin
                    m_mdr = mmem[a];
                    m_acc = m_mdr;
                    m_z   = (m_acc == 16'h0);
                    n     = 5;
                end
                4'h2: begin
                    mmem[a] = m_acc;
                    m_mdr   = m_acc;
                    exp_we++;
                    st = 1'b1;
                    n  = 4;
                end
                4'h3, 4'h4: begin
                    m_mdr = mmem[a];
                    m_acc = (op == 4'h3) ? m_acc + m_mdr : m_acc - m_mdr;
                    m_z   = (m_acc == 16'h0);
                    n     = 5;
                end
                4'h5: begin
                    m_mdr = mmem[a];
                    if (m_mdr == 16'h0) begin
                        m_acc = 16'hFFFF;
                        m_err = 1'b1;
                        m_z   = 1'b0;
                        n     = 5;
                    end else begin
                        m_acc = m_acc / m_mdr;
                        m_z   = (m_acc == 16'h0);
                        exp_ld++;
                        n = 7 + div_lat;
                    end
                end
                4'h6: m_pc = a;
                4'h7: if (m_z) m_pc = a;
                4'hF: m_halt = 1'b1;
                default: ;
            endcase
        end
        cyc(n);
        chk("pc", 32'(pc), 32'(m_pc));
        chk("acc", 32'(acc), 32'(m_acc));
        chk("zflag", 32'(zflag), 32'(m_z));
        chk("div_err", 32'(div_err), 32'(m_err));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("we_pulses", 32'(we_cnt), 32'(exp_we));
        chk("load_pulses", 32'(ld_cnt), 32'(exp_ld));
        if (st) chk("mem", 32'(ram[a]), 32'(mmem[a]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        ram[8'h00] = 16'h1010;
        ram[8'h01] = 16'h3011;
        ram[8'h02] = 16'h2012;
        ram[8'h03] = 16'hF000;
        ram[8'h10] = 16'h0005;
        ram[8'h11] = 16'h0007;

        #3 rst = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_acc", 32'(acc), 32'h0000);
        chk("rst_z", 32'(zflag), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_div_err", 32'(div_err), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_load", 32'(div_load), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mreset();

        // LOAD 10; ADD 11; STORE 12; HALT
        repeat (4) step();
        chk("sum_mem12", 32'(ram[8'h12]), 32'h000C);
        chk("sum_pc", 32'(pc), 32'h04);
        chk("sum_halted", 32'(halted), 32'h1);
        repeat (2) step();

        // Asynchronous reset in the middle of ADD.
        ram[8'h12] = 16'h0000;
        hw_reset();
        step();
        cyc(2);
        #3 rst = 1'b0;
        #1;
        chk("async_pc", 32'(pc), 32'h00);
        chk("async_acc", 32'(acc), 32'h0000);
        chk("async_z", 32'(zflag), 32'h0);
        chk("async_we", 32'(mem_we), 32'h0);
        #14 rst = 1'b1;
        @(negedge clk);
        mreset();
        step();
        chk("restart_pc", 32'(pc), 32'h01);
        repeat (3) step();
        chk("restart_mem12", 32'(ram[8'h12]), 32'h000C);

        // Wrap to zero, JZ taken/not taken, divide, divide by zero, PC wrap.
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        ram[8'h00] = 16'h1040;
        ram[8'h01] = 16'h3041;
        ram[8'h02] = 16'h7020;
        ram[8'h20] = 16'h1042;
        ram[8'h21] = 16'h7005;
        ram[8'h22] = 16'h5030;
        ram[8'h23] = 16'h5031;
        ram[8'h24] = 16'h60FF;
        ram[8'hFF] = 16'h9000;
        ram[8'h40] = 16'hFFFF;
        ram[8'h41] = 16'h0001;
        ram[8'h42] = 16'h0064;
        ram[8'h30] = 16'h0007;
        ram[8'h31] = 16'h0000;
        hw_reset();
        step();
        step();
        chk("wrap_acc", 32'(acc), 32'h0000);
        chk("wrap_z", 32'(zflag), 32'h1);
        step();
        chk("jz_taken_pc", 32'(pc), 32'h20);
        step();
        step();
        chk("jz_not_taken_pc", 32'(pc), 32'h22);
        div_lat = 3;
        step();
        chk("div_acc", 32'(acc), 32'h000E);
        chk("div_z", 32'(zflag), 32'h0);
        chk("div_stable", 32'(unstable), 32'h0);
        step();
        chk("div0_acc", 32'(acc), 32'hFFFF);
        chk("div0_err", 32'(div_err), 32'h1);
        step();
        chk("jmp_pc", 32'(pc), 32'hFF);
        step();
        chk("pc_wrap", 32'(pc), 32'h00);
        step();

        // Random programs against the reference model.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++) begin
                if (i < 48) begin
                    rop = 4'($urandom_range(0, 15));
                    if (rop == 4'hF && $urandom_range(0, 3) != 0) rop = 4'h3;
                    ram[i] = {rop, 4'h0, 8'($urandom_range(0, 255))};
                end else begin
                    case ($urandom_range(0, 3))
                        0:       ram[i] = 16'h0;
                        1:       ram[i] = 16'($urandom_range(1, 20));
                        default: ram[i] = 16'($urandom);
                    endcase
                end
            end
            hw_reset();
            repeat (150) begin
                div_lat = int'($urandom_range(1, 4));
                step();
            end
        end
        chk("div_stable_all", 32'(unstable), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_cpu_ctrl.md
Name: acc_cpu_ctrl

Overview:
Multicycle fetch/decode/execute sequencer and register file for the 16-bit accumulator CPU. It sits directly upstream of the 16-bit iterative divider and the single-port RAM. It drives the RAM address, write data and write enable that the top level exports as MemRW_IO, MemAddr_IO and MemD_IO. It launches divides, consumes the quotient, and owns PC, IR, ACC, MDR, MAR and Z.

Parameters:
ADDR_W, 8, width of PC, MAR and the RAM address.
DATA_W, 16, width of IR, ACC, MDR and the RAM data.
RESET_PC, 8'h00, PC value after reset.

Ports:
clk  in  1  single system clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset.
mem_addr  out  ADDR_W  RAM address.
mem_we  out  1  RAM write strobe, 1 cycle per store.
mem_wdata  out  DATA_W  RAM write data.
mem_rdata  in  DATA_W  RAM read data, combinational from mem_addr.
div_a  out  DATA_W  dividend, equal to ACC.
div_b  out  DATA_W  divisor, equal to MDR.
div_load  out  1  divide start pulse.
div_done  in  1  divider done; stays high until the next load.
div_q  in  DATA_W  quotient.
pc  out  ADDR_W  current PC (debug).
acc  out  DATA_W  current ACC (debug).
zflag  out  1  zero flag.
halted  out  1  set by HALT.
div_err  out  1  sticky divide-by-zero flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC; IR, ACC, MDR, MAR = 0.
  - zflag=0, halted=0, div_err=0; state=F1.
  - mem_we=0, div_load=0.
  - Reset mid-instruction or mid-divide aborts immediately; no partial write completes.
- Instruction word: IR[15:12] is the opcode, IR[7:0] is the operand address.
- Opcodes:
  - 0 NOP; 1 LOAD; 2 STORE; 3 ADD; 4 SUB; 5 DIV; 6 JMP; 7 JZ; F HALT.
  - Opcodes 8 through E execute as NOP.
- FSM states: F1, F2, DEC, RD, ALU, ST, DCHK, DW1, DW2, HALT.
- Each state:
  - F1: MAR<=PC.
  - F2: mem_addr=MAR; IR<=mem_rdata; PC<=PC+1, wrapping FF->00.
  - DEC: MAR<=IR[7:0].
    - NOP -> F1.
    - JMP: PC<=IR[7:0], -> F1.
    - JZ: PC<=IR[7:0] only if zflag=1, -> F1.
    - HALT -> HALT.
    - STORE -> ST.
    - LOAD, ADD, SUB, DIV -> RD.
  - RD: mem_addr=MAR; MDR<=mem_rdata. DIV -> DCHK; all others -> ALU.
  - ALU: ACC<=MDR (LOAD), ACC+MDR (ADD) or ACC-MDR (SUB). Arithmetic is modulo 2^16 with no carry flag. -> F1.
  - ST: mem_we=1, mem_addr=MAR, mem_wdata=ACC; MDR<=ACC; -> F1. mem_we is 0 in every other state.
  - DCHK:
    - If MDR==0: ACC<=16'hFFFF, div_err<=1, divider not started, -> F1.
    - Otherwise: div_load=1 for exactly this cycle, -> DW1.
  - DW1: ignore div_done, which is still stale-high from the previous divide; -> DW2.
  - DW2: hold until div_done=1, then ACC<=div_q, -> F1.
  - HALT: terminal; halted=1; no memory writes; exit only by reset.
- Zflag is updated on every ACC write (ALU, DCHK, DW2) to (ACC_next==0). It is unchanged otherwise.
- div_a and div_b are combinational copies of ACC and MDR. They remain constant from DCHK through DW2, because the divider resamples them every cycle.
- Cycle counts:
  - NOP, JMP and JZ: 3 cycles.
  - STORE: 4 cycles.
  - LOAD, ADD and SUB: 5 cycles.
  - DIV: 6 cycles plus divider latency; 5 cycles on divide-by-zero.

Decomposition:
- Shared package acc_cpu_pkg holds the opcode localparams (OP_NOP through OP_HALT), the state encoding, and the IR field positions.
- One sub-module, acc_cpu_regs, holds PC, IR, ACC, MDR, MAR and Z. It takes per-register load enables and next values and has an asynchronous active-low reset.
- The FSM and next-value muxing stay in acc_cpu_ctrl.

Test Plan:
- Reset: drop rst for 1.5 cycles mid-ADD -> pc=00, acc=0000, zflag=0, mem_we=0 asynchronously. Fetch restarts at address 00.
- Load/add/store: MEM[10]=0005, MEM[11]=0007, program LOAD 10; ADD 11; STORE 12; HALT -> MEM[12]=000C with exactly one mem_we pulse, halted=1, pc=04, 14 cycles before HALT state.
- Wrap and zero: ACC=FFFF, ADD of 0001 -> acc=0000, zflag=1. A following JZ 20 sets pc=20; with zflag=0 pc advances by 1 instead.
- Divide: ACC=0064, MEM[30]=0007, DIV 30 against the real divider -> div_load high for exactly 1 cycle, stale div_done ignored in DW1, acc=000E, zflag=0, div_a/div_b stable throughout.
- Divide by zero: MEM[31]=0000, DIV 31 -> div_load never asserted, acc=FFFF, div_err=1, next instruction fetched.
- PC wrap: JMP FF with NOP at FF -> after the fetch at FF, pc=00. Opcode 9 executes as NOP in 3 cycles.
